// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel mux: mode codes, auto-scan state and the
// wrap-around channel search used when a scan slot ends.
package tdm_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Upper bound on CH that next_enabled can search; masks are zero-extended to this.
    localparam int MAX_CH = 32;
    localparam int MAX_W  = $clog2(MAX_CH);

    typedef enum logic {
        NONE = 1'b0,
        SCAN = 1'b1
    } auto_state_e;

    // Lowest set index strictly after cur, wrapping to 0; an out-of-range cur searches from 0.
    function automatic int next_enabled(input logic [MAX_CH-1:0] mask, input int cur, input int n);
        int   base;
        int   idx;
        logic found;
        base         = (cur >= n) ? n - 1 : cur;
        next_enabled = base;
        found        = 1'b0;
        idx          = 0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= n) begin
                idx = (base + i) % n;
                if (!found && mask[idx[MAX_W-1:0]]) begin
                    next_enabled = idx;
                    found        = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/tdm_prescaler.sv
// Scan-slot timer: counts 0..PRESCALE-1 and flags the last cycle of the slot on tc.
module tdm_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tc
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_mux_scan.sv
// Registered CH-way channel mux with manual select or prescaled auto-scan over enabled channels.
module tdm_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CH       = 4,
    parameter int SEL_W    = $clog2(CH),
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] din,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [CH-1:0]       en_mask,
    output logic [WIDTH-1:0]    dout,
    output logic [SEL_W-1:0]    ch_idx,
    output logic [CH-1:0]       ch_onehot,
    output logic                slot_start
);

    import tdm_pkg::*;

    localparam int BASE_W = (CH * WIDTH > 1) ? $clog2(CH * WIDTH) : 1;

    auto_state_e        state_q, state_d;
    logic               mode_q, mode_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [SEL_W-1:0]   ch_idx_q, ch_idx_d;
    logic [CH-1:0]      ch_onehot_q, ch_onehot_d;
    logic               slot_start_q, slot_start_d;

    logic               pre_clear;
    logic               pre_hold;
    logic               pre_tc;
    logic               new_slot;
    logic               cur_en;
    logic [SEL_W-1:0]   after_cur;
    logic [MAX_CH-1:0]  mask_ext;
    logic [BASE_W-1:0]  base;
    int                 cur_i;
    int                 sel_i;

    tdm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pre_clear),
        .hold  (pre_hold),
        .tc    (pre_tc)
    );

    assign mask_ext = MAX_CH'(en_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= NONE;
            mode_q       <= MODE_MANUAL;
            cur_q        <= '0;
            dout_q       <= '0;
            ch_idx_q     <= '0;
            ch_onehot_q  <= '0;
            slot_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cur_q        <= cur_d;
            dout_q       <= dout_d;
            ch_idx_q     <= ch_idx_d;
            ch_onehot_q  <= ch_onehot_d;
            slot_start_q <= slot_start_d;
        end
    end

    // A new slot starts on entry to auto, on leaving NONE, at terminal count, or when cur is disabled.
    always_comb begin
        cur_i     = int'(cur_q);
        cur_en    = (cur_i < CH) && en_mask[cur_q];
        after_cur = SEL_W'(next_enabled(mask_ext, cur_i, CH));
        mode_d    = mode;
        state_d   = state_q;
        cur_d     = cur_q;
        pre_clear = 1'b0;
        pre_hold  = 1'b0;
        new_slot  = 1'b0;
        if (mode == MODE_MANUAL) begin
            state_d   = SCAN;
            cur_d     = sel;
            pre_clear = 1'b1;
        end else if (en_mask == '0) begin
            state_d   = NONE;
            pre_hold  = (state_q == NONE) && (mode_q == MODE_AUTO);
            pre_clear = !pre_hold;
        end else if ((mode_q == MODE_MANUAL) || (state_q == NONE)) begin
            state_d   = SCAN;
            cur_d     = cur_en ? cur_q : after_cur;
            pre_clear = 1'b1;
            new_slot  = 1'b1;
        end else if (!cur_en || pre_tc) begin
            cur_d     = after_cur;
            pre_clear = 1'b1;
            new_slot  = 1'b1;
        end
    end

    always_comb begin
        sel_i        = int'(sel);
        base         = '0;
        dout_d       = '0;
        ch_idx_d     = ch_idx_q;
        ch_onehot_d  = '0;
        slot_start_d = 1'b0;
        if (mode == MODE_MANUAL) begin
            ch_idx_d = sel;
            if (sel_i < CH) begin
                base        = BASE_W'(sel_i * WIDTH);
                dout_d      = din[base +: WIDTH];
                ch_onehot_d = CH'(1) << sel;
            end
        end else if (state_d == SCAN) begin
            base         = BASE_W'(int'(cur_d) * WIDTH);
            dout_d       = din[base +: WIDTH];
            ch_idx_d     = cur_d;
            ch_onehot_d  = CH'(1) << cur_d;
            slot_start_d = new_slot;
        end
    end

    assign dout       = dout_q;
    assign ch_idx     = ch_idx_q;
    assign ch_onehot  = ch_onehot_q;
    assign slot_start = slot_start_q;

endmodule

// File: doc/tdm_mux_scan.md
Name: tdm_mux_scan

Overview:
- Parametrised, registered successor to the team's 4-to-1 single-bit mux.
- Selects one of CH channels, each WIDTH bits wide.
- Two modes:
  - manual: an external select picks the channel.
  - auto-scan: a prescaled counter time-division-scans the enabled channels.
- Drives the seven-segment digit-scan path and generic channel sharing in the lab top levels.

Parameters:
- WIDTH, 4: bits per channel.
- CH, 4: number of channels, at least 2.
- SEL_W, $clog2(CH): select and index width (derived; do not override).
- PRESCALE, 16: clock cycles per scan slot in auto mode, at least 1.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- din  in  CH*WIDTH  packed channel data; channel k occupies din[k*WIDTH +: WIDTH].
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  channel select, used in manual mode only.
- en_mask  in  CH  per-channel enable; used in auto mode only.
- dout  out  WIDTH  registered selected data.
- ch_idx  out  SEL_W  index of the channel currently driving dout.
- ch_onehot  out  CH  one-hot of ch_idx, active-high; all zero when no channel is selected.
- slot_start  out  1  one-cycle pulse on the first cycle of each new auto slot.

Behaviour:
- Reset, sampled at a clk edge while rst_n=0: dout=0, ch_idx=0, ch_onehot=0, slot_start=0, prescaler=0, internal cur=0, mode_q=0. Reset mid-scan aborts the slot immediately.
- All outputs are registered. Latency is 1 cycle from din/sel/mask to dout/ch_idx/ch_onehot. din is sampled live every cycle; it is not held per slot.
- Manual mode (mode=0):
  - Each cycle, dout <= din[sel], ch_idx <= sel, ch_onehot <= 1<<sel.
  - If sel >= CH (only possible when CH is not a power of 2): dout <= 0, ch_onehot <= 0, ch_idx <= sel.
  - Prescaler holds at 0. slot_start=0. cur tracks sel.
- Auto mode (mode=1). States are SCAN and NONE:
  - NONE: entered when en_mask==0. dout=0, ch_onehot=0, ch_idx holds, prescaler held at 0. Leaves to SCAN on the cycle after any mask bit is set. The first slot starts at the lowest enabled index at or above cur (with wrap), and slot_start pulses.
  - SCAN: prescaler increments each cycle.
    - At prescaler==PRESCALE-1: prescaler <= 0, cur <= next enabled index after cur (wrap CH-1 -> 0), slot_start pulses in the following cycle.
    - If exactly one channel is enabled, cur stays the same, but slot_start still pulses every PRESCALE cycles.
  - cur disabled mid-slot (en_mask[cur] drops): advance to the next enabled channel on the next edge, restart the prescaler at 0, and pulse slot_start.
  - Outputs each cycle: dout <= din[cur], ch_idx <= cur, ch_onehot <= 1<<cur.
- Mode transitions, detected via mode_q:
  - Manual to auto: prescaler cleared. Scan starts from cur = last sel if that channel is enabled; otherwise from the next enabled channel. slot_start pulses.
  - Auto to manual: takes effect the next cycle. Prescaler cleared.
- Simultaneous terminal count and mask change in the same cycle: the next-channel search uses the current-cycle en_mask.
- PRESCALE=1: the channel advances every cycle, and slot_start stays high continuously while at least 2 channels are enabled.

Decomposition:
- Shared package (tdm_pkg):
  - mode encodings MODE_MANUAL=1'b0 and MODE_AUTO=1'b1.
  - auto state enum {NONE, SCAN}.
  - function next_enabled(mask, cur): returns the lowest set index strictly after cur, with wrap.
- One sub-module, tdm_prescaler: a PRESCALE-cycle counter with clear, hold, and tc outputs.
- Channel selection stays inline as an indexed part-select. The 4:1 gate-level mux is not instantiated.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with din=16'hABCD, mode=0, sel=2, then release. dout=0, ch_onehot=0 during reset; dout=4'hB and ch_onehot=4'b0100 one cycle after release.
- Manual sweep: sel=0,1,2,3 on consecutive cycles with din=16'h4321. dout=1,2,3,4 each one cycle late; ch_idx matches sel delayed by 1.
- Auto scan: PRESCALE=4, en_mask=4'b1111, mode 0->1 with sel=0.
  - ch_idx sequence is 0,0,0,0,1,1,1,1,2,... and wraps from 3 to 0.
  - slot_start pulses every 4 cycles, with the first pulse on the entry cycle.
- Mask skip: en_mask=4'b1010 during auto. ch_idx alternates 1 and 3 only. Clearing bit 3 mid-slot moves ch_idx to 1 on the next cycle, with the prescaler restarted and slot_start pulsed.
- All disabled: en_mask=0 in auto. dout=0 and ch_onehot=0 within 1 cycle. Setting en_mask=4'b0100 gives ch_idx=2 and a slot_start pulse.
- Reset mid-slot: rst_n=0 at prescaler=2 during auto. All outputs are 0 the next cycle, and the scan restarts at the first enabled channel at or above index 0 after release.
